// File: rtl/fft_pkg.sv
// Shared FFT sizing and the pair record carried from issue to write-back.
// N fixes every derived width; all fft_* files import this package.
package fft_pkg;

  localparam int unsigned N             = 32;
  localparam int unsigned log2_n        = $clog2(N);
  localparam int unsigned addr_width    = $clog2(N);
  localparam int unsigned stage_width   = $clog2($clog2(N));
  localparam int unsigned pair_id_width = $clog2(N / 2);

  typedef struct packed {
    logic [addr_width-1:0] addr_a;
    logic [addr_width-1:0] addr_b;
    logic                  bank;
  } pair_req;

endpackage

// File: rtl/fft_pair_tracker_if.sv
// Driver <-> tracker bundle: issue fields toward the tracker, butterfly read/write
// requests and pipeline status back toward the driver and memory.
interface fft_pair_tracker_if;
  import fft_pkg::*;

  logic                     valid;
  logic [stage_width-1:0]   stage;
  logic [pair_id_width-1:0] pair_id;
  logic                     bank_select;

  logic                     rd_en;
  logic [addr_width-1:0]    rd_addr_a;
  logic [addr_width-1:0]    rd_addr_b;
  logic                     rd_bank;
  logic [pair_id_width-1:0] tw_idx;

  logic                     wr_en;
  logic [addr_width-1:0]    wr_addr_a;
  logic [addr_width-1:0]    wr_addr_b;
  logic                     wr_bank;

  logic                     pipeline_clear;
  logic                     proto_err;

  modport master (
    output valid, stage, pair_id, bank_select,
    input  rd_en, rd_addr_a, rd_addr_b, rd_bank, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, wr_bank,
           pipeline_clear, proto_err
  );

  modport slave (
    input  valid, stage, pair_id, bank_select,
    output rd_en, rd_addr_a, rd_addr_b, rd_bank, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, wr_bank,
           pipeline_clear, proto_err
  );

endinterface

// File: rtl/fft_delay_line.sv
// LATENCY-deep shift register of pair requests with a valid bit per stage.
// Data shifts every cycle; only the valid bit marks a real entry.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    in_vld,
  input  pair_req in_req,
  output logic    out_vld,
  output pair_req out_req
);

  logic [LATENCY-1:0] vld_q, vld_d;
  pair_req            req_q [LATENCY];
  pair_req            req_d [LATENCY];

  always_comb begin
    vld_d[0] = in_vld;
    req_d[0] = in_req;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      req_d[i] = req_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        req_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      req_q <= req_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_req = req_q[LATENCY-1];

endmodule

// File: rtl/fft_pair_tracker.sv
// Responder for the FFT compute driver: converts stage/pair issues into radix-2 butterfly reads,
// tracks them to write-back. Optional protocol checker: define FFT_PAIR_TRACKER_CHECK_EN.
module fft_pair_tracker
  import fft_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input logic               clk,
  input logic               reset_n,
  fft_pair_tracker_if.slave bus
);

  localparam int unsigned InFlightW = $clog2(LATENCY + 2);

  logic [addr_width-1:0]    span, offset, grp, addr_a, addr_b;
  logic [stage_width-1:0]   tw_shift;
  logic [pair_id_width-1:0] tw;

  // Butterfly operands sit `span` apart inside groups of 2*span samples.
  always_comb begin
    span     = addr_width'(1) << bus.stage;
    offset   = addr_width'(bus.pair_id) & (span - addr_width'(1));
    grp      = addr_width'(bus.pair_id) >> bus.stage;
    addr_a   = ((grp << bus.stage) << 1) + offset;
    addr_b   = addr_a + span;
    tw_shift = stage_width'(log2_n - 1) - bus.stage;
    tw       = pair_id_width'(offset) << tw_shift;
  end

  logic                     rd_en_q, rd_en_d;
  logic [addr_width-1:0]    rd_addr_a_q, rd_addr_a_d;
  logic [addr_width-1:0]    rd_addr_b_q, rd_addr_b_d;
  logic [pair_id_width-1:0] tw_idx_q, tw_idx_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [InFlightW-1:0]     in_flight_q, in_flight_d;

  pair_req iss_req, tail_req;
  logic    tail_vld;

  always_comb begin
    rd_en_d     = bus.valid;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_idx_d    = tw_idx_q;
    rd_bank_d   = rd_bank_q;
    wr_bank_d   = wr_bank_q;
    if (bus.valid) begin
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_b;
      tw_idx_d    = tw;
      rd_bank_d   = bus.bank_select;
      // Out-of-place ping-pong: results land in the opposite bank.
      wr_bank_d   = ~bus.bank_select;
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    case ({bus.valid, tail_vld})
      2'b10:   in_flight_d = in_flight_q + InFlightW'(1);
      2'b01:   in_flight_d = in_flight_q - InFlightW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      in_flight_q <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      in_flight_q <= in_flight_d;
    end
  end

  // Fed from the issue register so write-back trails rd_en by exactly LATENCY cycles.
  always_comb begin
    iss_req        = '0;
    iss_req.addr_a = rd_addr_a_q;
    iss_req.addr_b = rd_addr_b_q;
    iss_req.bank   = wr_bank_q;
  end

  fft_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (rd_en_q),
    .in_req  (iss_req),
    .out_vld (tail_vld),
    .out_req (tail_req)
  );

  assign bus.rd_en          = rd_en_q;
  assign bus.rd_addr_a      = rd_addr_a_q;
  assign bus.rd_addr_b      = rd_addr_b_q;
  assign bus.tw_idx         = tw_idx_q;
  assign bus.rd_bank        = rd_bank_q;
  assign bus.wr_en          = tail_vld;
  assign bus.wr_addr_a      = tail_req.addr_a;
  assign bus.wr_addr_b      = tail_req.addr_b;
  assign bus.wr_bank        = tail_req.bank;
  assign bus.pipeline_clear = (in_flight_q == '0) & ~bus.valid;

`ifdef FFT_PAIR_TRACKER_CHECK_EN
  logic [stage_width-1:0]   last_stage_q, last_stage_d;
  logic [pair_id_width-1:0] last_pair_q, last_pair_d;
  logic                     prev_vld_q, prev_vld_d;
  logic                     proto_err_q, proto_err_d;
  logic                     stage_viol, pair_viol;

  always_comb begin
    stage_viol = prev_vld_q && (bus.stage != last_stage_q) && (in_flight_q != '0);
    // Pair 0 may restart a stage at any time.
    pair_viol  = prev_vld_q && (bus.stage == last_stage_q) && (bus.pair_id != '0) &&
                 (bus.pair_id != last_pair_q + pair_id_width'(1));
    last_stage_d = last_stage_q;
    last_pair_d  = last_pair_q;
    prev_vld_d   = prev_vld_q;
    proto_err_d  = proto_err_q;
    if (bus.valid) begin
      last_stage_d = bus.stage;
      last_pair_d  = bus.pair_id;
      prev_vld_d   = 1'b1;
      if (stage_viol || pair_viol) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_stage_q <= '0;
      last_pair_q  <= '0;
      prev_vld_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      last_stage_q <= last_stage_d;
      last_pair_q  <= last_pair_d;
      prev_vld_q   <= prev_vld_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.proto_err = proto_err_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_pair_tracker.sv
// Bench for fft_pair_tracker: directed vectors plus random issues against an
// issue-history reference model (addresses recomputed with plain arithmetic).
module tb_fft_pair_tracker;
  import fft_pkg::*;

  localparam int Lat  = 4;
  localparam int L2   = $clog2(N);
  localparam int MaxC = 4096;
`ifdef FFT_PAIR_TRACKER_CHECK_EN
  localparam bit ProtoOn = 1'b1;
`else
  localparam bit ProtoOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   rst_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Issue history: what the driver presented (and the DUT sampled) in each cycle.
  bit hv  [MaxC];
  int hs  [MaxC];
  int hp  [MaxC];
  bit hbk [MaxC];

  fft_pair_tracker_if bus ();

  fft_pair_tracker #(
    .LATENCY (Lat)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ref_pair(input int s, input int p, output int a, output int b,
                                   output int tw);
    int span;
    span = 1 << s;
    a    = (p / span) * 2 * span + (p % span);
    b    = a + span;
    tw   = (p % span) << (L2 - 1 - s);
  endfunction

  function automatic bit issued(input int k);
    return (k >= rst_cyc) && (k < cyc) && hv[k];
  endfunction

  function automatic int last_issue(input int k);
    for (int j = k; j >= rst_cyc; j--) begin
      if (hv[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive(input bit v, input int s, input int p, input bit bs);
    bus.valid       = v;
    bus.stage       = stage_width'(s);
    bus.pair_id     = pair_id_width'(p);
    bus.bank_select = bs;
  endtask

  task automatic tick();
    hv[cyc]  = bus.valid && reset_n;
    hs[cyc]  = int'(bus.stage);
    hp[cyc]  = int'(bus.pair_id);
    hbk[cyc] = bus.bank_select;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_cyc = cyc;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    checks++;
    if ({bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank,
         bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank, bus.proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_en=%0b wr_en=%0b ra=%0d rb=%0d tw=%0d pe=%0b want 0",
               bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.proto_err);
    end
    checks++;
    if (bus.pipeline_clear !== 1'b1) begin
      errors++;
      $display("FAIL reset_clear_idle: got %0b want 1", bus.pipeline_clear);
    end
    bus.valid = 1'b1;
    #1;
    checks++;
    if (bus.pipeline_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear_valid: got %0b want 0", bus.pipeline_clear);
    end
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_cyc = cyc;
  endtask

  task automatic test_addr_table();
    int tbl [3][6];
    tbl = '{'{0, 5, 0, 10, 11, 0}, '{2, 5, 1, 9, 13, 4}, '{4, 15, 0, 15, 31, 15}};
    for (int v = 0; v < 3; v++) begin
      drive(1, tbl[v][0], tbl[v][1], tbl[v][2] != 0);
      #1;
      checks++;
      if (bus.pipeline_clear !== 1'b0) begin
        errors++;
        $display("FAIL tbl%0d_clear_t: got %0b want 0", v, bus.pipeline_clear);
      end
      tick();
      drive(0, tbl[v][0], tbl[v][1], tbl[v][2] != 0);
      for (int d = 1; d <= Lat + 2; d++) begin
        #1;
        if (d <= 2) begin
          checks++;
          if ({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank} !==
              {(d == 1), addr_width'(tbl[v][3]), addr_width'(tbl[v][4]),
               pair_id_width'(tbl[v][5]), (tbl[v][2] != 0)}) begin
            errors++;
            $display("FAIL tbl%0d_rd_d%0d: got en=%0b a=%0d b=%0d tw=%0d bk=%0b want a=%0d b=%0d tw=%0d",
                     v, d, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank,
                     tbl[v][3], tbl[v][4], tbl[v][5]);
          end
        end
        checks++;
        if (bus.wr_en !== (d == Lat + 1)) begin
          errors++;
          $display("FAIL tbl%0d_wr_en_d%0d: got %0b want %0b", v, d, bus.wr_en, (d == Lat + 1));
        end
        if (d == Lat + 1) begin
          checks++;
          if ({bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank} !==
              {addr_width'(tbl[v][3]), addr_width'(tbl[v][4]), (tbl[v][2] == 0)}) begin
            errors++;
            $display("FAIL tbl%0d_wr: got a=%0d b=%0d bk=%0b want a=%0d b=%0d bk=%0b", v,
                     bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank, tbl[v][3], tbl[v][4],
                     (tbl[v][2] == 0));
          end
        end
        checks++;
        if (bus.pipeline_clear !== (d == Lat + 2)) begin
          errors++;
          $display("FAIL tbl%0d_clear_d%0d: got %0b want %0b", v, d, bus.pipeline_clear,
                   (d == Lat + 2));
        end
        if (d < Lat + 2) tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_rd, exp_wr, exp_clr;
    for (int d = 0; d <= 18 + Lat; d++) begin
      if (d < 16) drive(1, 0, d, d % 2);
      else        drive(0, 0, 0, 0);
      #1;
      exp_rd  = (d >= 1) && (d <= 16);
      exp_wr  = (d >= 1 + Lat) && (d <= 16 + Lat);
      exp_clr = (d >= 17 + Lat);
      checks++;
      if ({bus.rd_en, bus.wr_en, bus.pipeline_clear} !== {exp_rd, exp_wr, exp_clr}) begin
        errors++;
        $display("FAIL b2b_d%0d: got rd=%0b wr=%0b clr=%0b want rd=%0b wr=%0b clr=%0b", d,
                 bus.rd_en, bus.wr_en, bus.pipeline_clear, exp_rd, exp_wr, exp_clr);
      end
      if (exp_wr) begin
        checks++;
        if (bus.wr_addr_a !== addr_width'(2 * (d - 1 - Lat))) begin
          errors++;
          $display("FAIL b2b_wr_addr_d%0d: got %0d want %0d", d, bus.wr_addr_a, 2 * (d - 1 - Lat));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i, 1);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank,
         bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank, bus.pipeline_clear} !== 1) begin
      errors++;
      $display("FAIL midrst_outputs: got rd=%0b wr=%0b ra=%0d rb=%0d bk=%0b clr=%0b want zeros, clr=1",
               bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b, bus.rd_bank,
               bus.pipeline_clear);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_cyc = cyc;
    for (int d = 0; d < Lat + 4; d++) begin
      #1;
      checks++;
      if ({bus.rd_en, bus.wr_en, bus.pipeline_clear} !== 3'b001) begin
        errors++;
        $display("FAIL midrst_after_d%0d: got rd=%0b wr=%0b clr=%0b want 0 0 1", d, bus.rd_en,
                 bus.wr_en, bus.pipeline_clear);
      end
      tick();
    end
  endtask

  task automatic test_proto();
    drive(1, 1, 3, 0);
    tick();
    drive(1, 1, 5, 0);
    #1;
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_before: got %0b want 0", bus.proto_err);
    end
    tick();
    drive(0, 0, 0, 0);
    for (int d = 0; d < Lat + 3; d++) begin
      #1;
      checks++;
      if (bus.proto_err !== ProtoOn) begin
        errors++;
        $display("FAIL proto_held_d%0d: got %0b want %0b", d, bus.proto_err, ProtoOn);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int  j, k, ea, eb, et, wa, wb, wt;
    bit  v, ebk, ewr, busy;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 2) != 0);
      drive(v, $urandom_range(0, L2 - 1), $urandom_range(0, N / 2 - 1), $urandom_range(0, 1));
      #1;
      j = last_issue(cyc - 1);
      ea = 0; eb = 0; et = 0; ebk = 0;
      if (j >= 0) begin
        ref_pair(hs[j], hp[j], ea, eb, et);
        ebk = hbk[j];
      end
      checks++;
      if ({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank} !==
          {issued(cyc - 1), addr_width'(ea), addr_width'(eb), pair_id_width'(et), ebk}) begin
        errors++;
        $display("FAIL rand_rd_n%0d: got en=%0b a=%0d b=%0d tw=%0d bk=%0b want en=%0b a=%0d b=%0d tw=%0d bk=%0b",
                 n, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.rd_bank,
                 issued(cyc - 1), ea, eb, et, ebk);
      end
      k   = cyc - 1 - Lat;
      ewr = issued(k);
      checks++;
      if (bus.wr_en !== ewr) begin
        errors++;
        $display("FAIL rand_wr_en_n%0d: got %0b want %0b", n, bus.wr_en, ewr);
      end
      if (ewr) begin
        ref_pair(hs[k], hp[k], wa, wb, wt);
        checks++;
        if ({bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank} !==
            {addr_width'(wa), addr_width'(wb), !hbk[k]}) begin
          errors++;
          $display("FAIL rand_wr_n%0d: got a=%0d b=%0d bk=%0b want a=%0d b=%0d bk=%0b", n,
                   bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank, wa, wb, !hbk[k]);
        end
      end
      busy = 1'b0;
      for (int m = cyc - 1 - Lat; m <= cyc - 1; m++) busy |= issued(m);
      checks++;
      if (bus.pipeline_clear !== (!v && !busy)) begin
        errors++;
        $display("FAIL rand_clear_n%0d: got %0b want %0b", n, bus.pipeline_clear, (!v && !busy));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_addr_table();
    test_back_to_back();
    test_reset_mid();
    test_proto();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_pair_tracker.md
# fft_pair_tracker

Responder side of the FFT compute-driver protocol. Accepts `stage`/`pair_id`/`valid`/`bank_select` issues from the compute driver and converts each into a radix-2 butterfly read request (two sample addresses, twiddle index, read bank). It tracks every issued pair through a fixed-latency butterfly pipeline, emits the matching write-back request, and returns `pipeline_clear` to the driver so it can advance stages.

## Interface
- `N`, 32, FFT size, power of two ≥ 4
- `LATENCY`, 4, cycles from `rd_en` to matching `wr_en` (memory read plus butterfly), ≥ 1
- `stage_width`, $clog2($clog2(N)), stage field width
- `pair_id_width`, $clog2(N/2), pair field width
- `addr_width`, $clog2(N), sample address width

Ports:
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `valid`  in  1  issue strobe from driver
- `stage`  in  stage_width  current FFT stage
- `pair_id`  in  pair_id_width  butterfly index within stage
- `bank_select`  in  1  ping-pong bank for reads
- `rd_en`  out  1  read request
- `rd_addr_a`, `rd_addr_b`  out  addr_width  butterfly operand addresses
- `rd_bank`  out  1  bank to read
- `tw_idx`  out  pair_id_width  twiddle ROM index
- `wr_en`  out  1  write-back request
- `wr_addr_a`, `wr_addr_b`  out  addr_width  write-back addresses
- `wr_bank`  out  1  bank to write
- `pipeline_clear`  out  1  no pairs in flight and no issue this cycle
- `proto_err`  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- Address generation, L = $clog2(N), s = `stage`, p = `pair_id`: span = 1<<s; offset = p & (span-1); group = p >> s; a = group·2·span + offset; b = a + span; tw = offset << (L-1-s). All unsigned, truncated to port widths.
- `rd_bank` = `bank_select`; `wr_bank` = ~`bank_select` captured at issue (out-of-place ping-pong; write addresses equal read addresses).
- Issue register: on a sampled `valid`, register rd_* outputs and push {a, b, wr_bank} into a LATENCY-deep delay line with a valid bit. Without `valid`, `rd_en` = 0 and address outputs hold.
- Delay-line tail drives `wr_en`/`wr_addr_*`/`wr_bank`.
- `in_flight` counter, width $clog2(LATENCY+2): +1 on sampled `valid`, −1 on `wr_en`, unchanged when both occur. Max LATENCY+1; never wraps.
- `pipeline_clear` = (`in_flight` == 0) & ~`valid`. Combinational from a register and the `valid` input. Low during the cycle the driver issues its last pair, so the driver drops `valid`.
- No back-pressure: every issue is accepted.

## Timing
- `valid` sampled at edge t → `rd_en` and read fields visible in cycle t+1 → `wr_en` visible in cycle t+1+LATENCY.
- Back-to-back issues give one `rd_en`/`wr_en` per cycle with no bubbles.
- `pipeline_clear` rises in the cycle after the last `wr_en` when `valid` is low.
- Reset values (async, immediate): `rd_en` = `wr_en` = 0, all address/bank/`tw_idx` outputs 0, delay-line valid bits 0, `in_flight` = 0, `proto_err` = 0, `pipeline_clear` = ~`valid`.
- Reset mid-stage discards all in-flight pairs. No `wr_en` follows.

## Configuration
- `FFT_PAIR_TRACKER_CHECK_EN` defined: `proto_err` sets and holds until reset on either violation:
  - a `valid` whose `stage` differs from the previous issued stage while `in_flight` ≠ 0
  - a `valid` whose `pair_id` ≠ previous issued `pair_id`+1 within the same stage, except `pair_id` 0
- Undefined: `proto_err` tied 0 and checker registers absent.

## Structure
- Shared package `fft_pkg`: `N`-derived widths (`addr_width`, `stage_width`, `pair_id_width`) and a `pair_req` record type {addr_a, addr_b, bank}.
- One sub-module: `fft_delay_line`, a parameterised LATENCY-deep shift register with a valid bit. The address-generation math stays inline.

## Test plan
- N=32, LATENCY=4: stage 0, pair 5, bank_select=0 → cycle t+1: rd_addr_a=10, rd_addr_b=11, tw_idx=0, rd_bank=0; cycle t+5: wr_en=1, wr_addr 10/11, wr_bank=1.
- Stage 2, pair 5 → a=9, b=13, tw_idx=4. Stage 4, pair 15 → a=15, b=31, tw_idx=15.
- Issue 16 back-to-back pairs of stage 0 → 16 consecutive `rd_en` then 16 consecutive `wr_en`; `pipeline_clear` low throughout and high in the cycle after the 16th `wr_en`.
- Single issue, then `valid` low → `pipeline_clear` = 0 for cycles t..t+5 and 1 from t+6.
- Assert `reset_n` low with 3 pairs in flight → outputs zero immediately, no `wr_en` after release, `pipeline_clear` = 1.
- With `FFT_PAIR_TRACKER_CHECK_EN`: issue pair 3 then pair 5 in the same stage → `proto_err` = 1 and held. Without the macro, same stimulus → `proto_err` = 0.
